mc_sequencer: RTL and testbench

Multi-cycle control sequencer for the simple MIPS datapath. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath strobes state by state. It shares one memory port between instruction fetch and data access using a ready handshake. It sits between the top-level run control and the datapath, and replaces single-cycle static decode.

---
 rtl/mc_ctrl_pkg.sv | 40 ++++
 rtl/mc_op_decode.sv | 25 ++
 rtl/mc_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_mc_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_ctrl_pkg;

    // Registered 3-bit sequencer state.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Opcode field values understood by the sequencer.
    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd3;
    localparam logic [5:0] OP_AND = 6'd5;
    localparam logic [5:0] OP_OR  = 6'd7;
    localparam logic [5:0] OP_LW  = 6'd4;
    localparam logic [5:0] OP_SW  = 6'd2;

    // ALUOp codes presented to the datapath ALU.
    localparam logic [1:0] ALUOP_AND = 2'd0;
    localparam logic [1:0] ALUOP_OR  = 2'd1;
    localparam logic [1:0] ALUOP_ADD = 2'd2;
    localparam logic [1:0] ALUOP_SUB = 2'd3;

    // Opcode decode result.
    typedef struct packed {
        logic       legal;
        logic       is_rtype;
        logic       is_load;
        logic       is_store;
        logic [1:0] alu_op;
    } op_dec_t;

endpackage

// File: rtl/mc_op_decode.sv
// Opcode classifier: legality, instruction class and ALUOp.
// Latency: purely combinational.
// Backpressure: none.
module mc_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_dec_t    dec
);

    // Map each known opcode to its class and ALU operation; unknown stays illegal.
    always_comb begin
        dec = '0;
        case (opcode)
            OP_ADD: begin dec.legal = 1'b1; dec.is_rtype = 1'b1; dec.alu_op = ALUOP_ADD; end
            OP_SUB: begin dec.legal = 1'b1; dec.is_rtype = 1'b1; dec.alu_op = ALUOP_SUB; end
            OP_AND: begin dec.legal = 1'b1; dec.is_rtype = 1'b1; dec.alu_op = ALUOP_AND; end
            OP_OR:  begin dec.legal = 1'b1; dec.is_rtype = 1'b1; dec.alu_op = ALUOP_OR;  end
            OP_LW:  begin dec.legal = 1'b1; dec.is_load  = 1'b1; dec.alu_op = ALUOP_ADD; end
            OP_SW:  begin dec.legal = 1'b1; dec.is_store = 1'b1; dec.alu_op = ALUOP_ADD; end
            default: dec = '0;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) sharing one memory port; optional perf counters via MC_SEQ_PERF_EN.
// Latency: R-type and store 4 cycles, load 5 cycles with MemReady high; each MemReady-low cycle adds one.
// Backpressure: FETCH/MEM hold their request until MemReady; MEM_WAIT_MAX consecutive waits halt with MemTimeout.
module mc_sequencer
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [5:0]       Opcode,
    input  logic             MemReady,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic [1:0]       ALUOp,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             IllegalOp,
    output logic             MemTimeout,
    output logic             Busy,
    output logic [CNT_W-1:0] InstrCount,
    output logic [CNT_W-1:0] CycleCount
);

    // Wait counter just wide enough to reach MEM_WAIT_MAX.
    localparam int WCW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WCW:0] WAIT_LIM = (WCW + 1)'(MEM_WAIT_MAX);
    localparam logic [WCW:0] WAIT_ONE = (WCW + 1)'(1);

    state_t         state_q, state_d;
    logic [5:0]     opcode_q, opcode_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           illegal_q, illegal_d;
    logic           timeout_q, timeout_d;

    logic [WCW:0]   wait_inc;
    logic           wait_expired;
    logic [5:0]     dec_opcode;
    op_dec_t        dec;
    logic           busy;

    // In DECODE the live opcode is judged; afterwards the latched copy drives the strobes.
    assign dec_opcode = (state_q == ST_DECODE) ? Opcode : opcode_q;

    mc_op_decode u_op_decode (
        .opcode (dec_opcode),
        .dec    (dec)
    );

    // This wait cycle would be the MEM_WAIT_MAX-th consecutive one (never when the limit is 0).
    assign wait_inc     = {1'b0, wait_cnt_q} + WAIT_ONE;
    assign wait_expired = (MEM_WAIT_MAX != 0) && (wait_inc == WAIT_LIM);
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_HALT);

    // State, latched opcode, wait counter and sticky flags; Reset beats everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            opcode_q   <= '0;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next state and per-state datapath strobes.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        wait_cnt_d = '0;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegDst     = 1'b0;
        ALUSrc     = 1'b0;
        ALUOp      = ALUOP_AND;
        MemToReg   = 1'b0;
        RegWrite   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                MemRead = 1'b1;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    wait_cnt_d = wait_inc[WCW-1:0];
                end
            end
            ST_DECODE: begin
                opcode_d = Opcode;
                if (dec.legal) begin
                    state_d = ST_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_EXEC: begin
                ALUOp   = dec.alu_op;
                ALUSrc  = dec.is_load | dec.is_store;
                state_d = (dec.is_load | dec.is_store) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                IorD     = 1'b1;
                ALUSrc   = 1'b1;
                ALUOp    = ALUOP_ADD;
                MemRead  = dec.is_load;
                MemWrite = dec.is_store;
                if (MemReady) begin
                    if (dec.is_load) state_d = ST_WB;
                    else             state_d = Run ? ST_FETCH : ST_IDLE;
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    wait_cnt_d = wait_inc[WCW-1:0];
                end
            end
            ST_WB: begin
                // ALU controls stay as in EXEC so the result is stable while it is written.
                RegWrite = 1'b1;
                RegDst   = dec.is_rtype;
                MemToReg = dec.is_load;
                ALUOp    = dec.alu_op;
                ALUSrc   = dec.is_load | dec.is_store;
                state_d  = Run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign IllegalOp  = illegal_q;
    assign MemTimeout = timeout_q;
    assign Busy       = busy;

`ifdef MC_SEQ_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             instr_ret;

    // An instruction retires when WB is left or a store's memory access completes.
    always_comb begin
        instr_ret   = (state_q == ST_WB) || ((state_q == ST_MEM) && dec.is_store && MemReady);
        instr_cnt_d = instr_ret ? (instr_cnt_q + CNT_ONE) : instr_cnt_q;
        cycle_cnt_d = busy ? (cycle_cnt_q + CNT_ONE) : cycle_cnt_q;
    end

    // Free-running, wrapping performance counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign InstrCount = instr_cnt_q;
    assign CycleCount = cycle_cnt_q;
`else
    assign InstrCount = '0;
    assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: stimulus queues a hand-computed strobe vector per cycle,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_mc_sequencer;
    localparam int CNT_W = 32;

    logic             Clk = 1'b0;
    logic             Reset, Run, MemReady;
    logic [5:0]       Opcode;
    logic             IorD, MemRead, MemWrite, IRWrite, PCWrite, RegDst, ALUSrc;
    logic [1:0]       ALUOp;
    logic             MemToReg, RegWrite, IllegalOp, MemTimeout, Busy;
    logic [CNT_W-1:0] InstrCount, CycleCount;

    mc_sequencer #(.MEM_WAIT_MAX(15), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Opcode(Opcode), .MemReady(MemReady),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .IllegalOp(IllegalOp),
        .MemTimeout(MemTimeout), .Busy(Busy), .InstrCount(InstrCount), .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [13:0] exp_q[$];
    int          trace_idx = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Vector layout: Busy MemTimeout IllegalOp RegWrite MemToReg ALUOp[1:0] ALUSrc RegDst PCWrite IRWrite MemWrite MemRead IorD
    function automatic logic [13:0] ev(input logic busy, to, ill, rw, m2r, input logic [1:0] aop,
                                       input logic asrc, rdst, pcw, irw, mw, mr, iord);
        return {busy, to, ill, rw, m2r, aop, asrc, rdst, pcw, irw, mw, mr, iord};
    endfunction

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            logic [13:0] e;
            logic [13:0] act;
            e   = exp_q.pop_front();
            act = {Busy, MemTimeout, IllegalOp, RegWrite, MemToReg, ALUOp, ALUSrc, RegDst,
                   PCWrite, IRWrite, MemWrite, MemRead, IorD};
            check($sformatf("trace[%0d]", trace_idx), {18'd0, act}, {18'd0, e});
            trace_idx++;
        end
    end

    // One cycle: drive inputs just after the edge, queue what the DUT must show this cycle.
    task automatic step(input logic run, input logic [5:0] op, input logic rdy, input logic [13:0] e);
        Run      = run;
        Opcode   = op;
        MemReady = rdy;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Run = 1'b0; MemReady = 1'b0; Opcode = 6'd0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [13:0] E_IDLE, E_FW, E_FR, E_DEC, E_EXADD, E_WBADD, E_EXMEM, E_MLD, E_WBLD,
                     E_MST, E_HILL, E_HTO, E_EXSUB, E_WBSUB;
        E_IDLE  = 14'd0;
        E_FW    = ev(1,0,0,0,0,2'd0,0,0,0,0,0,1,0);
        E_FR    = ev(1,0,0,0,0,2'd0,0,0,1,1,0,1,0);
        E_DEC   = ev(1,0,0,0,0,2'd0,0,0,0,0,0,0,0);
        E_EXADD = ev(1,0,0,0,0,2'd2,0,0,0,0,0,0,0);
        E_WBADD = ev(1,0,0,1,0,2'd2,0,1,0,0,0,0,0);
        E_EXMEM = ev(1,0,0,0,0,2'd2,1,0,0,0,0,0,0);
        E_MLD   = ev(1,0,0,0,0,2'd2,1,0,0,0,0,1,1);
        E_WBLD  = ev(1,0,0,1,1,2'd2,1,0,0,0,0,0,0);
        E_MST   = ev(1,0,0,0,0,2'd2,1,0,0,0,1,0,1);
        E_HILL  = ev(0,0,1,0,0,2'd0,0,0,0,0,0,0,0);
        E_HTO   = ev(0,1,0,0,0,2'd0,0,0,0,0,0,0,0);
        E_EXSUB = ev(1,0,0,0,0,2'd3,0,0,0,0,0,0,0);
        E_WBSUB = ev(1,0,0,1,0,2'd3,0,1,0,0,0,0,0);

        Reset = 1'b1; Run = 1'b0; MemReady = 1'b0; Opcode = 6'd0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Reset state, then ADD with zero wait states: FETCH..WB then FETCH at cycle 4.
        step(0, 6'd1, 1, E_IDLE);
        step(1, 6'd1, 1, E_IDLE);
        step(1, 6'd1, 1, E_FR);
        step(1, 6'd1, 1, E_DEC);
        step(1, 6'd1, 1, E_EXADD);
        step(1, 6'd1, 1, E_WBADD);
        // Load with three MEM wait cycles: 8 cycles FETCH..WB.
        step(1, 6'd4, 1, E_FR);
        step(1, 6'd4, 1, E_DEC);
        step(1, 6'd4, 1, E_EXMEM);
        step(1, 6'd4, 0, E_MLD);
        step(1, 6'd4, 0, E_MLD);
        step(1, 6'd4, 0, E_MLD);
        step(1, 6'd4, 1, E_MLD);
        step(1, 6'd4, 1, E_WBLD);
        // Store: MemWrite without MemRead, no WB, straight back to FETCH.
        step(1, 6'd2, 1, E_FR);
        step(1, 6'd2, 1, E_DEC);
        step(1, 6'd2, 1, E_EXMEM);
        step(1, 6'd2, 1, E_MST);
        // 14 fetch waits then MemReady on the cycle the limit would be hit: no timeout.
        for (int i = 0; i < 14; i++) step(1, 6'd6, 0, E_FW);
        step(1, 6'd6, 1, E_FR);
        // Illegal opcode 6: HALT after DECODE, stays there with Run high.
        step(1, 6'd6, 1, E_DEC);
        for (int i = 0; i < 3; i++) step(1, 6'd6, 1, E_HILL);

        // Reset clears IllegalOp; then 15 fetch waits trigger MemTimeout.
        do_reset();
        step(0, 6'd1, 0, E_IDLE);
        step(1, 6'd1, 0, E_IDLE);
        for (int i = 0; i < 15; i++) step(1, 6'd1, 0, E_FW);
        step(1, 6'd1, 0, E_HTO);
        step(1, 6'd1, 1, E_HTO);

        // Reset clears MemTimeout; SUB with Run dropped in EXEC finishes WB then parks in IDLE.
        do_reset();
        step(0, 6'd3, 1, E_IDLE);
        check("perf_reset_instr", InstrCount, 32'd0);
        check("perf_reset_cycle", CycleCount, 32'd0);
        step(1, 6'd3, 1, E_IDLE);
        step(1, 6'd3, 1, E_FR);
        step(1, 6'd3, 1, E_DEC);
        step(0, 6'd3, 1, E_EXSUB);
        step(0, 6'd3, 1, E_WBSUB);
        step(0, 6'd3, 1, E_IDLE);
        step(0, 6'd3, 1, E_IDLE);
`ifdef MC_SEQ_PERF_EN
        check("instr_count", InstrCount, 32'd1);
        check("cycle_count", CycleCount, 32'd4);
`else
        check("instr_count", InstrCount, 32'd0);
        check("cycle_count", CycleCount, 32'd0);
`endif
        @(negedge Clk);
        check("trace_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
